dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the single-port data memory. Port 0 serves the CPU memory stage; port 1 serves the program loader/debug port. The block sequences each access over a fixed multi-cycle latency and handles RISC-V byte, half-word and word sizing with sign/zero extension. It returns a per-port done pulse, and port 0 exposes a busy level that freezes the pipeline.

## Interface
- LATENCY, 4: memory access cycles per granted request (≥1).
- ADDR_W, 6: word-address width of the memory (2^ADDR_W words).

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pN_req  in  1  request, level; N = 0, 1.
- pN_we  in  1  1 = store, 0 = load.
- pN_funct3  in  3  RISC-V load/store funct3.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  store data, low-aligned.
- pN_done  out  1  one-cycle completion pulse.
- pN_err  out  1  valid with done; 1 = misaligned or illegal funct3.
- pN_rdata  out  32  load result, valid with done, held until the next done for that port.
- p0_busy  out  1  p0_req && !p0_done, combinational.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap.
- mem_wdata  out  32  lane-replicated store data.
- mem_wmask  out  4  byte-lane write mask.
- mem_rdata  in  32  memory read word, valid combinationally while mem_en is high.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples requests each cycle.
  - If any request is granted and legal, go to ACCESS and latch the granted port's we, funct3, addr and wdata.
  - If the granted request is illegal, go directly to RESP with err=1.
- ACCESS:
  - 8-bit counter runs 1..LATENCY.
  - mem_en=1 throughout ACCESS.
  - mem_we=1 only in the last ACCESS cycle, and only for stores.
  - At the end of the last cycle: loads capture the extended mem_rdata; the FSM goes to RESP.
- RESP:
  - Granted port's done=1 for exactly one cycle, then IDLE.
  - Requests are not sampled in RESP.
- Arbitration: round-robin.
  - Register last_grant resets to 1, so port 0 wins the first tie.
  - On simultaneous requests, the port ≠ last_grant wins.
  - A lone requester always wins.
  - last_grant updates on every grant, including illegal ones.
- Latched operands are used for the whole access. Dropping req mid-access does not abort it; done still pulses.
- Lane = addr[1:0].
- Loads:
  - LB (000) sign-extends the byte at lane; LBU (100) zero-extends it.
  - LH (001) sign-extends the half at addr[1]; LHU (101) zero-extends it.
  - LW (010) returns the full word.
- Stores:
  - SB: wdata[7:0] replicated ×4, mask = 1<<lane.
  - SH: wdata[15:0] replicated ×2, mask = 0011 or 1100.
  - SW: mask = 1111.
- Illegal requests:
  - Cases: half access with addr[0]=1; word access with addr[1:0]≠0; funct3 ∈ {011, 110, 111}; store with funct3[2]=1.
  - Result: no memory activity, rdata=0, err=1.
- After RESP the FSM samples again in IDLE. A CPU holding req high for a new instruction in the following cycle is treated as a new request.

## Timing
- Reset (asynchronous):
  - FSM → IDLE, counter=0, last_grant=1.
  - All done, err, rdata and mem_* outputs become 0 immediately.
  - An in-flight store is never written. No done is produced for the aborted access.
- Legal access: req sampled in cycle c → ACCESS in c+1..c+LATENCY → done in c+LATENCY+1 → IDLE in c+LATENCY+2.
- Illegal access: done/err in c+1.
- Minimum request-to-request period per port: LATENCY+2 cycles.
- While the FSM is not IDLE, a waiting request gets no grant; its port's busy stays high.
- mem_* outputs are registered from the latched request.

## Test plan
- LW, LATENCY=4: mem word 5 = 0x80FF1234; p0 LW addr 0x14 at cycle 0 → mem_en cycles 1–4, p0_done cycle 5, p0_rdata=0x80FF1234, p0_busy high cycles 0–4.
- Sub-word loads on word 0x80FF1234 → results:
  - LB addr 2 → 0xFFFFFFFF.
  - LBU addr 3 → 0x00000080.
  - LH addr 2 → 0xFFFF80FF.
  - LHU addr 0 → 0x00001234.
- SB, SH, SW:
  - SB addr 0x07, wdata 0xAB → mem_addr 1, wmask 1000, wdata 0xABABABAB, mem_we only in cycle 4.
  - SH addr 0x06 → mask 1100.
  - SW addr 0x08 → mask 1111.
- Contention: p0 and p1 request continuously from cycle 0 → grants alternate p0, p1, p0, with done pulses every 6 cycles, starting with p0 at cycle 5.
- Illegal requests:
  - LW addr 0x02 → done+err in cycle 1, rdata 0, mem_en never high.
  - SB with funct3=100 → same response.
- Reset mid-access: SW asserted, rst low in cycle 3 → outputs 0 at once, memory unchanged. After release, an LW to the same address returns the old value.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and fixed-latency access sequencer for the
// single-port data memory, with RISC-V byte/half/word sizing and extension.
module dmem_arbiter #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned ADDR_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [2:0]        p0_funct3,
   input  logic [31:0]       p0_addr,
   input  logic [31:0]       p0_wdata,
   output logic              p0_done,
   output logic              p0_err,
   output logic [31:0]       p0_rdata,
   output logic              p0_busy,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [2:0]        p1_funct3,
   input  logic [31:0]       p1_addr,
   input  logic [31:0]       p1_wdata,
   output logic              p1_done,
   output logic              p1_err,
   output logic [31:0]       p1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic [31:0]       mem_rdata
);

   localparam logic [7:0] LAT8 = 8'(LATENCY);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef struct packed {
      logic       we;
      logic [2:0] funct3;
      logic [1:0] lane;
   } lat_req_t;

   state_t          state;
   logic [7:0]      cnt;
   logic            last_grant;
   lat_req_t        lat;

   logic            gnt;
   logic            g_we;
   logic [2:0]      g_f3;
   logic [ADDR_W+1:0] g_addr;
   logic [31:0]     g_wdata;
   logic            g_legal;
   logic [31:0]     st_wdata;
   logic [3:0]      st_mask;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [31:0]     ld_val;
   logic [31:0]     resp_data;
   logic            unused_addr;

   // Address bits above the memory size are ignored, so accesses wrap.
   assign unused_addr = ^{p0_addr[31:ADDR_W+2], p1_addr[31:ADDR_W+2]};

   assign p0_busy = p0_req && !p0_done;

   function automatic logic legal_req(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lane);
      logic ok;
      ok = 1'b0;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = !lane[0];
         3'b010:  ok = (lane == 2'b00);
         3'b100:  ok = !we;
         3'b101:  ok = !we && !lane[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Round-robin pick: on a tie the port that did not win last time is served.
   always_comb begin
      gnt      = p1_req && (!p0_req || !last_grant);
      g_we     = gnt ? p1_we     : p0_we;
      g_f3     = gnt ? p1_funct3 : p0_funct3;
      g_addr   = gnt ? p1_addr[ADDR_W+1:0] : p0_addr[ADDR_W+1:0];
      g_wdata  = gnt ? p1_wdata  : p0_wdata;
      g_legal  = legal_req(g_we, g_f3, g_addr[1:0]);
      st_wdata = g_wdata;
      st_mask  = 4'b1111;
      case (g_f3[1:0])
         2'b00: begin
            st_wdata = {4{g_wdata[7:0]}};
            st_mask  = 4'b0001 << g_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{g_wdata[15:0]}};
            st_mask  = g_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = g_wdata;
            st_mask  = 4'b1111;
         end
      endcase
   end

   // Load lane selection and sign/zero extension from the latched request.
   always_comb begin
      ld_byte = mem_rdata[{lat.lane, 3'b000} +: 8];
      ld_half = lat.lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_val  = mem_rdata;
      case (lat.funct3)
         3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_val = {24'h000000, ld_byte};
         3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_val = {16'h0000, ld_half};
         default: ld_val = mem_rdata;
      endcase
      resp_data = lat.we ? 32'h0 : ld_val;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         last_grant <= 1'b1;
         lat        <= '0;
         p0_done    <= 1'b0;
         p0_err     <= 1'b0;
         p0_rdata   <= 32'h0;
         p1_done    <= 1'b0;
         p1_err     <= 1'b0;
         p1_rdata   <= 32'h0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 32'h0;
         mem_wmask  <= 4'b0000;
      end else begin
         p0_done <= 1'b0;
         p1_done <= 1'b0;
         case (state)
            IDLE: begin
               if (p0_req || p1_req) begin
                  last_grant <= gnt;
                  if (g_legal) begin
                     state      <= ACCESS;
                     cnt        <= 8'd1;
                     lat.we     <= g_we;
                     lat.funct3 <= g_f3;
                     lat.lane   <= g_addr[1:0];
                     mem_en     <= 1'b1;
                     mem_we     <= g_we && (LAT8 == 8'd1);
                     mem_addr   <= g_addr[ADDR_W+1:2];
                     mem_wdata  <= g_we ? st_wdata : 32'h0;
                     mem_wmask  <= g_we ? st_mask : 4'b0000;
                  end else begin
                     // Illegal request: answer at once, memory untouched.
                     state <= RESP;
                     if (gnt) begin
                        p1_done  <= 1'b1;
                        p1_err   <= 1'b1;
                        p1_rdata <= 32'h0;
                     end else begin
                        p0_done  <= 1'b1;
                        p0_err   <= 1'b1;
                        p0_rdata <= 32'h0;
                     end
                  end
               end
            end
            ACCESS: begin
               if (cnt == LAT8) begin
                  state     <= RESP;
                  cnt       <= 8'd0;
                  mem_en    <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= 32'h0;
                  mem_wmask <= 4'b0000;
                  if (last_grant) begin
                     p1_done  <= 1'b1;
                     p1_err   <= 1'b0;
                     p1_rdata <= resp_data;
                  end else begin
                     p0_done  <= 1'b1;
                     p0_err   <= 1'b0;
                     p0_rdata <= resp_data;
                  end
               end else begin
                  cnt    <= cnt + 8'd1;
                  mem_we <= lat.we && (cnt == LAT8 - 8'd1);
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: loads, stores, arbitration, illegal
// requests and asynchronous reset against a small word memory model.
module tb_dmem_arbiter;
   localparam int unsigned ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              p0_req = 1'b0, p0_we = 1'b0;
   logic [2:0]        p0_funct3 = 3'b000;
   logic [31:0]       p0_addr = 32'h0, p0_wdata = 32'h0;
   logic              p0_done, p0_err, p0_busy;
   logic [31:0]       p0_rdata;
   logic              p1_req = 1'b0, p1_we = 1'b0;
   logic [2:0]        p1_funct3 = 3'b000;
   logic [31:0]       p1_addr = 32'h0, p1_wdata = 32'h0;
   logic              p1_done, p1_err;
   logic [31:0]       p1_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;
   logic [3:0]        mem_wmask;

   logic [31:0]       mem [64];
   logic              pre_en = 1'b0;
   logic [ADDR_W-1:0] pre_addr = '0;
   logic [31:0]       pre_data = 32'h0;
   int                wr_count;
   int                checks;
   int                passes;

   dmem_arbiter #(.LATENCY(4), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p0_busy(p0_busy),
      .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_addr] <= pre_data;
      end else if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         wr_count <= wr_count + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      pre_addr = a; pre_data = d; pre_en = 1'b1;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic drive(input bit port, input logic req, input logic we,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      if (port) begin
         p1_req = req; p1_we = we; p1_funct3 = f3; p1_addr = addr; p1_wdata = wdata;
      end else begin
         p0_req = req; p0_we = we; p0_funct3 = f3; p0_addr = addr; p0_wdata = wdata;
      end
   endtask

   // Issues one request at cycle 0 and records a 10-cycle window of activity.
   task automatic run_access(input bit port, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [9:0] en_b, output logic [9:0] we_b,
                             output logic [9:0] done_b, output logic [9:0] busy_b,
                             output logic err_s, output logic [31:0] rdata_s,
                             output logic [ADDR_W-1:0] maddr_s, output logic [31:0] mwdata_s,
                             output logic [3:0] mask_s);
      logic seen;
      seen = 1'b0; en_b = '0; we_b = '0; done_b = '0; busy_b = '0;
      err_s = 1'b0; rdata_s = 32'h0; maddr_s = '0; mwdata_s = 32'h0; mask_s = 4'h0;
      drive(port, 1'b1, we, f3, addr, wdata);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         en_b[k] = mem_en; we_b[k] = mem_we; busy_b[k] = p0_busy;
         if (port ? p1_done : p0_done) begin
            done_b[k] = 1'b1; seen = 1'b1;
            err_s   = port ? p1_err : p0_err;
            rdata_s = port ? p1_rdata : p0_rdata;
         end
         if (k == 1) begin maddr_s = mem_addr; mwdata_s = mem_wdata; mask_s = mem_wmask; end
         @(posedge clk); #1;
         if (seen) drive(port, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      end
   endtask

   task automatic test_reset();
      #3 rst = 1'b0; #1;
      checks++; if ({p0_done, p1_done, p0_err, p1_err, mem_en, mem_we, p0_busy} !== 7'b0)
         $display("FAIL reset_flags got %b want 0000000", {p0_done, p1_done, p0_err, p1_err, mem_en, mem_we, p0_busy});
      else passes++;
      checks++; if ({p0_rdata, p1_rdata, mem_wdata} !== 96'h0)
         $display("FAIL reset_data got %h %h %h want 0", p0_rdata, p1_rdata, mem_wdata); else passes++;
      checks++; if ({mem_addr, mem_wmask} !== 10'h0)
         $display("FAIL reset_addr_mask got %h %b want 0", mem_addr, mem_wmask); else passes++;
      p0_req = 1'b1; #1;
      checks++; if (p0_busy !== 1'b1) $display("FAIL reset_busy got %b want 1", p0_busy); else passes++;
      p0_req = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_lw();
      logic [9:0] en_b, we_b, done_b, busy_b; logic err_s; logic [31:0] rd, wd;
      logic [ADDR_W-1:0] ma; logic [3:0] mk;
      preload(6'd5, 32'h80FF1234);
      run_access(1'b0, 1'b0, 3'b010, 32'h14, 32'h0, en_b, we_b, done_b, busy_b, err_s, rd, ma, wd, mk);
      checks++; if (en_b !== 10'h01E) $display("FAIL lw_mem_en got %b want %b", en_b, 10'h01E); else passes++;
      checks++; if (we_b !== 10'h000) $display("FAIL lw_mem_we got %b want 0", we_b); else passes++;
      checks++; if (done_b !== 10'h020) $display("FAIL lw_done got %b want %b", done_b, 10'h020); else passes++;
      checks++; if (busy_b !== 10'h01F) $display("FAIL lw_busy got %b want %b", busy_b, 10'h01F); else passes++;
      checks++; if (rd !== 32'h80FF1234) $display("FAIL lw_rdata got %h want 80ff1234", rd); else passes++;
      checks++; if (err_s !== 1'b0) $display("FAIL lw_err got %b want 0", err_s); else passes++;
      checks++; if (ma !== 6'd5) $display("FAIL lw_mem_addr got %0d want 5", ma); else passes++;
      checks++; if (p0_rdata !== 32'h80FF1234) $display("FAIL lw_rdata_held got %h want 80ff1234", p0_rdata); else passes++;
   endtask

   task automatic test_subword_loads();
      logic [2:0] f3s [4]; logic [31:0] adrs [4]; logic [31:0] exps [4];
      logic [9:0] en_b, we_b, done_b, busy_b; logic err_s; logic [31:0] rd, wd;
      logic [ADDR_W-1:0] ma; logic [3:0] mk;
      f3s  = '{3'b000, 3'b100, 3'b001, 3'b101};
      adrs = '{32'h2, 32'h3, 32'h2, 32'h0};
      exps = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00001234};
      preload(6'd0, 32'h80FF1234);
      for (int i = 0; i < 4; i++) begin
         run_access(1'b0, 1'b0, f3s[i], adrs[i], 32'h0, en_b, we_b, done_b, busy_b, err_s, rd, ma, wd, mk);
         checks++; if (rd !== exps[i] || done_b !== 10'h020)
            $display("FAIL subload_%0d got %h done %b want %h done %b", i, rd, done_b, exps[i], 10'h020);
         else passes++;
      end
   endtask

   task automatic test_stores();
      bit ports [3]; logic [2:0] f3s [3]; logic [31:0] adrs [3]; logic [31:0] wds [3];
      logic [ADDR_W-1:0] eaddr [3]; logic [31:0] ewd [3]; logic [3:0] emk [3]; logic [31:0] emem [3];
      logic [9:0] en_b, we_b, done_b, busy_b; logic err_s; logic [31:0] rd, wd;
      logic [ADDR_W-1:0] ma; logic [3:0] mk;
      ports = '{1'b0, 1'b0, 1'b1};
      f3s   = '{3'b000, 3'b001, 3'b010};
      adrs  = '{32'h07, 32'h06, 32'h08};
      wds   = '{32'h000000AB, 32'h1234BEEF, 32'hDEADBEEF};
      eaddr = '{6'd1, 6'd1, 6'd2};
      ewd   = '{32'hABABABAB, 32'hBEEFBEEF, 32'hDEADBEEF};
      emk   = '{4'b1000, 4'b1100, 4'b1111};
      emem  = '{32'hAB223344, 32'hBEEF3344, 32'hDEADBEEF};
      preload(6'd1, 32'h11223344);
      preload(6'd2, 32'h0);
      for (int i = 0; i < 3; i++) begin
         run_access(ports[i], 1'b1, f3s[i], adrs[i], wds[i], en_b, we_b, done_b, busy_b, err_s, rd, ma, wd, mk);
         checks++; if (mk !== emk[i]) $display("FAIL st%0d_mask got %b want %b", i, mk, emk[i]); else passes++;
         checks++; if (ma !== eaddr[i]) $display("FAIL st%0d_addr got %0d want %0d", i, ma, eaddr[i]); else passes++;
         checks++; if (wd !== ewd[i]) $display("FAIL st%0d_wdata got %h want %h", i, wd, ewd[i]); else passes++;
         checks++; if (we_b !== 10'h010) $display("FAIL st%0d_we got %b want %b", i, we_b, 10'h010); else passes++;
         checks++; if (done_b !== 10'h020 || err_s !== 1'b0)
            $display("FAIL st%0d_done got %b err %b want %b err 0", i, done_b, err_s, 10'h020); else passes++;
         checks++; if (mem[eaddr[i]] !== emem[i])
            $display("FAIL st%0d_mem got %h want %h", i, mem[eaddr[i]], emem[i]); else passes++;
      end
   endtask

   task automatic test_contention();
      logic [19:0] d0, d1, bz; logic [31:0] r0, r1;
      d0 = '0; d1 = '0; bz = '0; r0 = 32'h0; r1 = 32'h0;
      preload(6'd3, 32'h0BADF00D);
      drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10C, 32'h0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         d0[k] = p0_done; d1[k] = p1_done; bz[k] = p0_busy;
         if (p0_done) r0 = p0_rdata;
         if (p1_done) r1 = p1_rdata;
         @(posedge clk); #1;
         if (k == 17) begin
            drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         end
      end
      checks++; if (d0 !== 20'h20020) $display("FAIL rr_p0_done got %h want 20020", d0); else passes++;
      checks++; if (d1 !== 20'h00800) $display("FAIL rr_p1_done got %h want 00800", d1); else passes++;
      checks++; if (bz !== 20'h1FFDF) $display("FAIL rr_p0_busy got %h want 1ffdf", bz); else passes++;
      checks++; if (r0 !== 32'h80FF1234) $display("FAIL rr_p0_rdata got %h want 80ff1234", r0); else passes++;
      checks++; if (r1 !== 32'h0BADF00D) $display("FAIL rr_p1_wrap_rdata got %h want 0badf00d", r1); else passes++;
   endtask

   task automatic test_illegal();
      bit ports [5]; logic wes [5]; logic [2:0] f3s [5]; logic [31:0] adrs [5];
      logic [9:0] en_b, we_b, done_b, busy_b; logic err_s; logic [31:0] rd, wd;
      logic [ADDR_W-1:0] ma; logic [3:0] mk; int wc;
      ports = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      wes   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      f3s   = '{3'b010, 3'b100, 3'b001, 3'b111, 3'b010};
      adrs  = '{32'h02, 32'h00, 32'h05, 32'h00, 32'h0A};
      for (int i = 0; i < 5; i++) begin
         wc = wr_count;
         run_access(ports[i], wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, en_b, we_b, done_b, busy_b, err_s, rd, ma, wd, mk);
         checks++; if (done_b !== 10'h002 || err_s !== 1'b1)
            $display("FAIL ill%0d_done_err got %b err %b want %b err 1", i, done_b, err_s, 10'h002); else passes++;
         checks++; if (rd !== 32'h0) $display("FAIL ill%0d_rdata got %h want 0", i, rd); else passes++;
         checks++; if (en_b !== 10'h0 || wr_count !== wc)
            $display("FAIL ill%0d_mem got en %b writes %0d want en 0 writes %0d", i, en_b, wr_count, wc); else passes++;
      end
   endtask

   task automatic test_reset_mid_access();
      logic [9:0] en_b, we_b, done_b, busy_b; logic err_s; logic [31:0] rd, wd;
      logic [ADDR_W-1:0] ma; logic [3:0] mk; int wc; int nd;
      preload(6'd4, 32'h55667788);
      wc = wr_count; nd = 0;
      drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'hCAFEBABE);
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (mem_en !== 1'b1) $display("FAIL rmid_inflight got %b want 1", mem_en); else passes++;
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      #1;
      checks++; if ({mem_en, mem_we, p0_done, p0_err, p0_busy, mem_wmask} !== 9'h0)
         $display("FAIL rmid_flags got %b want 0", {mem_en, mem_we, p0_done, p0_err, p0_busy, mem_wmask}); else passes++;
      checks++; if ({p0_rdata, mem_wdata, mem_addr} !== 70'h0)
         $display("FAIL rmid_data got %h %h %h want 0", p0_rdata, mem_wdata, mem_addr); else passes++;
      @(negedge clk); rst = 1'b1;
      repeat (8) begin @(negedge clk); if (p0_done) nd++; end
      checks++; if (nd !== 0) $display("FAIL rmid_no_done got %0d want 0", nd); else passes++;
      checks++; if (mem[4] !== 32'h55667788 || wr_count !== wc)
         $display("FAIL rmid_mem got %h writes %0d want 55667788 writes %0d", mem[4], wr_count, wc); else passes++;
      @(posedge clk); #1;
      run_access(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, en_b, we_b, done_b, busy_b, err_s, rd, ma, wd, mk);
      checks++; if (rd !== 32'h55667788 || done_b !== 10'h020)
         $display("FAIL rmid_reload got %h done %b want 55667788 done %b", rd, done_b, 10'h020); else passes++;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_lw();
      test_subword_loads();
      test_stores();
      test_contention();
      test_illegal();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
